// File: rtl/gray_seq_pkg.sv
// gray_seq_pkg: shared state encoding and reference Gray conversion
package gray_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;
    function automatic logic [15:0] bin2gray(input logic [15:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_encode.sv
// gray_encode: combinational binary to Gray conversion
module gray_encode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray_seq_ctrl.sv
// gray_seq_ctrl: steps a binary counter through first..last and streams it Gray-encoded
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic             wrap,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] b_out,
    output logic             valid,
    input  logic             ready,
    output logic             busy,
    output logic             done
);
    seq_state_t       state;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] first_q;
    logic [WIDTH-1:0] last_q;
    logic             dir_q;
    logic             wrap_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bin     <= '0;
            first_q <= '0;
            last_q  <= '0;
            dir_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else if (state == IDLE) begin
            if (start) begin
                state   <= RUN;
                bin     <= first;
                first_q <= first;
                last_q  <= last;
                dir_q   <= dir;
                wrap_q  <= wrap;
            end
        end else if (state == RUN) begin
            // stop wins over both the step and the DONE transition
            if (stop) state <= IDLE;
            else if (ready) begin
                if (bin != last_q) bin <= dir_q ? bin - WIDTH'(1) : bin + WIDTH'(1);
                else if (wrap_q) bin <= first_q;
                else state <= DONE;
            end
        end else begin
            state <= IDLE;
        end
    end
    gray_encode #(.WIDTH(WIDTH)) u_enc (
        .bin  (bin),
        .gray (g_out)
    );
    assign b_out = bin;
    assign valid = state == RUN;
    assign busy  = state == RUN;
    assign done  = state == DONE;
endmodule

// File: tb/tb_gray_seq_ctrl.sv
// tb_gray_seq_ctrl: scoreboard bench for the Gray sequencer with directed vectors
module tb_gray_seq_ctrl;
    import gray_seq_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       dir = 1'b0;
    logic       wrap = 1'b0;
    logic [3:0] first = '0;
    logic [3:0] last = '0;
    logic [3:0] g_out;
    logic [3:0] b_out;
    logic       valid;
    logic       ready = 1'b1;
    logic       busy;
    logic       done;
    typedef struct {
        logic [3:0] b;
        logic [3:0] g;
        bit         jump;
    } beat_t;
    beat_t      sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] prev_g = '0;
    logic [3:0] g_up [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hc, 4'hd, 4'hf, 4'he, 4'ha, 4'hb, 4'h9, 4'h8};
    logic [3:0] b_dn [5] = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
    logic [3:0] g_dn [5] = '{4'h3, 4'h1, 4'h0, 4'h8, 4'h9};
    logic [3:0] g_wr [3] = '{4'h7, 4'h5, 4'h4};

    gray_seq_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .stop  (stop),
        .dir   (dir),
        .wrap  (wrap),
        .first (first),
        .last  (last),
        .g_out (g_out),
        .b_out (b_out),
        .valid (valid),
        .ready (ready),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] g4(input logic [3:0] b);
        logic [15:0] t;
        t = bin2gray({12'd0, b});
        return t[3:0];
    endfunction

    task automatic push(input logic [3:0] b, input logic [3:0] g, input bit j);
        sb.push_back('{b: b, g: g, jump: j});
    endtask

    task automatic start_seq(input logic [3:0] f, input logic [3:0] l, input logic d, input logic w);
        first = f;
        last  = l;
        dir   = d;
        wrap  = w;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        bit seen = 0;
        while (!seen && n < max) begin
            @(negedge clk);
            n++;
            if (done) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done: no done pulse within %0d cycles", name, max);
        end else begin
            chk({name, "_done_valid"}, 16'(valid), 16'd0);
            chk({name, "_done_busy"}, 16'(busy), 16'd0);
            chk({name, "_sb_empty"}, 16'(sb.size()), 16'd0);
            @(negedge clk);
            chk({name, "_done_once"}, 16'(done), 16'd0);
            chk({name, "_idle_valid"}, 16'(valid), 16'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted beat is popped and compared
    always @(negedge clk) begin
        if (valid && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got b=%0h g=%0h with empty queue", b_out, g_out);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("beat_b", 16'(b_out), 16'(e.b));
                chk("beat_g", 16'(g_out), 16'(e.g));
                if (!e.jump) chk("gray_step", 16'($countones(g_out ^ prev_g)), 16'd1);
            end
            prev_g = g_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 16'(valid), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_g", 16'(g_out), 16'd0);
        chk("rst_b", 16'(b_out), 16'd0);
        @(posedge clk);
        #1;
        // full up-count
        for (int i = 0; i < 16; i++) push(4'(i), g_up[i], i == 0);
        start_seq(4'd0, 4'd15, 1'b0, 1'b0);
        chk("t1_first_valid", 16'(valid), 16'd1);
        chk("t1_first_busy", 16'(busy), 16'd1);
        wait_done("t1", 40);
        // backpressure on beat 3
        for (int i = 0; i < 16; i++) push(4'(i), g_up[i], i == 0);
        start_seq(4'd0, 4'd15, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_valid", 16'(valid), 16'd1);
            chk("t2_hold_g", 16'(g_out), 16'h3);
            chk("t2_hold_b", 16'(b_out), 16'h2);
        end
        @(posedge clk);
        #1 ready = 1'b1;
        wait_done("t2", 40);
        // down-count through zero
        for (int i = 0; i < 5; i++) push(b_dn[i], g_dn[i], i == 0);
        start_seq(4'd2, 4'd14, 1'b1, 1'b0);
        wait_done("t3", 20);
        // start pulse while running must not disturb the sequence
        for (int i = 0; i < 16; i++) push(4'(i), g4(4'(i)), i == 0);
        start_seq(4'd0, 4'd15, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 start_seq(4'd9, 4'd9, 1'b1, 1'b1);
        dir  = 1'b0;
        wrap = 1'b0;
        wait_done("t_ign", 40);
        // single beat
        push(4'd9, 4'hd, 1'b1);
        start_seq(4'd9, 4'd9, 1'b0, 1'b0);
        wait_done("t6", 10);
        // free-run wrap, stop on the second 0100 beat
        for (int i = 0; i < 6; i++) push(4'(5 + i % 3), g_wr[i % 3], i % 3 == 0);
        start_seq(4'd5, 4'd7, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_stop_valid", 16'(valid), 16'd0);
            chk("t4_stop_done", 16'(done), 16'd0);
        end
        chk("t4_sb_empty", 16'(sb.size()), 16'd0);
        @(posedge clk);
        #1;
        // reset during beat 4
        for (int i = 0; i < 4; i++) push(4'(i), g_up[i], i == 0);
        start_seq(4'd0, 4'd15, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_valid", 16'(valid), 16'd0);
        chk("t5_busy", 16'(busy), 16'd0);
        chk("t5_g", 16'(g_out), 16'd0);
        chk("t5_b", 16'(b_out), 16'd0);
        chk("t5_done", 16'(done), 16'd0);
        chk("t5_sb_empty", 16'(sb.size()), 16'd0);
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
